// File: rtl/mem_access_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mem_access_pkg
// Shared definitions for the memory access controller: access-type encodings,
// FSM state encoding, default wait limit and an alignment helper.
// -----------------------------------------------------------------------------
package mem_access_pkg;

  // Default number of cycles a READ/WRITE phase waits for mem_ack
  localparam int MEM_TIMEOUT_DEF = 15;

  // Access types presented on the op input
  typedef enum logic [1:0] {
    OP_LW = 2'b00,  // load word
    OP_SW = 2'b01,  // store word
    OP_SH = 2'b10,  // store half (read-modify-write)
    OP_SB = 2'b11   // store byte (read-modify-write)
  } op_e;

  // Controller states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WRITE = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } state_e;

  // Word accesses must sit on a 4-byte boundary
  function automatic logic is_aligned(input logic [31:0] a);
    return (a[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl_if
// Memory-side bus of the access controller.
//   mem_addr  : byte address driven to memory (0 when idle)
//   mem_wdata : write data (0 when mem_wr is low)
//   mem_rd    : read request level
//   mem_wr    : write request level
//   mem_rdata : read data, valid with mem_ack during a read
//   mem_ack   : completion strobe for the current read or write
// master = controller side, slave = memory side.
// -----------------------------------------------------------------------------
interface mem_access_ctrl_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_addr, mem_wdata, mem_rd, mem_wr,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_rd, mem_wr,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mem_access_ctrl_store_merge.sv
// -----------------------------------------------------------------------------
// store_merge
// Combinational sub-word merge for stores. Half and byte stores keep the upper
// bytes of the word previously read into the MDR and replace the low bytes
// with store data.
//   op     : access type
//   mdr    : memory data register (word read in the READ phase)
//   wdata  : store data from the B register
//   merged : word to be written
// -----------------------------------------------------------------------------
module store_merge
  import mem_access_pkg::*;
(
  input  op_e         op,
  input  logic [31:0] mdr,
  input  logic [31:0] wdata,
  output logic [31:0] merged
);

  // Select the merged word for the current access type
  always_comb begin
    merged = mdr;
    case (op)
      OP_SW:   merged = wdata;
      OP_SH:   merged = {mdr[31:16], wdata[15:0]};
      OP_SB:   merged = {mdr[31:8], wdata[7:0]};
      default: merged = mdr;  // loads never write
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
// Load/store controller between a CPU datapath and a handshaked memory.
// Loads read one word into the MDR; word stores write directly; half and byte
// stores read the word first, merge the low bytes and write it back.
// Ports:
//   clk, reset : clock, synchronous active-low reset
//   start      : request an access (sampled only in IDLE)
//   op         : access type (see mem_access_pkg::op_e)
//   addr       : byte address, must be word aligned
//   wdata      : store data
//   mem        : memory bus (master side)
//   MDR_out    : memory data register
//   busy       : high while a READ or WRITE phase is in progress
//   done/err   : one-cycle completion / failure pulses
// Each READ/WRITE phase waits at most MEM_TIMEOUT cycles without ack: the wait
// counter holds the number of ack-less cycles so far, and a cycle in which it
// already equals MEM_TIMEOUT is the last chance; an ack there still succeeds.
// -----------------------------------------------------------------------------
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [1:0]               op,
  input  logic [31:0]              addr,
  input  logic [31:0]              wdata,
  mem_access_ctrl_if.master        mem,
  output logic [31:0]              MDR_out,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MEM_TIMEOUT);

  state_e           state_r, state_s;
  op_e              op_r, op_s;
  logic [31:0]      addr_r, addr_s;
  logic [31:0]      wdata_r, wdata_s;
  logic [31:0]      mdr_r, mdr_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;

  logic             mem_rd_r, mem_wr_r, busy_r, done_r, err_r;
  logic [31:0]      mem_addr_r;
  logic [31:0]      merged_s;

  store_merge u_store_merge (
    .op     (op_r),
    .mdr    (mdr_r),
    .wdata  (wdata_r),
    .merged (merged_s)
  );

  // Next-state, latch and wait-counter logic
  always_comb begin
    state_s = state_r;
    op_s    = op_r;
    addr_s  = addr_r;
    wdata_s = wdata_r;
    mdr_s   = mdr_r;
    cnt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          op_s    = op_e'(op);
          addr_s  = addr;
          wdata_s = wdata;
          cnt_s   = {CNT_W{1'b0}};
          if (!is_aligned(addr)) begin
            state_s = ST_ERR;
          end else if (op_e'(op) == OP_SW) begin
            state_s = ST_WRITE;
          end else begin
            state_s = ST_READ;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_READ: begin
        if (mem.mem_ack) begin
          mdr_s   = mem.mem_rdata;
          cnt_s   = {CNT_W{1'b0}};
          state_s = (op_r == OP_LW) ? ST_DONE : ST_WRITE;
        end else if (cnt_r == CNT_LIMIT) begin
          cnt_s   = {CNT_W{1'b0}};
          state_s = ST_ERR;
        end else begin
          cnt_s   = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_WRITE: begin
        if (mem.mem_ack) begin
          cnt_s   = {CNT_W{1'b0}};
          state_s = ST_DONE;
        end else if (cnt_r == CNT_LIMIT) begin
          cnt_s   = {CNT_W{1'b0}};
          state_s = ST_ERR;
        end else begin
          cnt_s   = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_DONE: state_s = ST_IDLE;
      ST_ERR:  state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State, latched request and registered outputs (decoded from next state)
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      op_r       <= OP_LW;
      addr_r     <= 32'h0;
      wdata_r    <= 32'h0;
      mdr_r      <= 32'h0;
      cnt_r      <= {CNT_W{1'b0}};
      mem_rd_r   <= 1'b0;
      mem_wr_r   <= 1'b0;
      mem_addr_r <= 32'h0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      state_r    <= state_s;
      op_r       <= op_s;
      addr_r     <= addr_s;
      wdata_r    <= wdata_s;
      mdr_r      <= mdr_s;
      cnt_r      <= cnt_s;
      mem_rd_r   <= (state_s == ST_READ);
      mem_wr_r   <= (state_s == ST_WRITE);
      mem_addr_r <= ((state_s == ST_READ) || (state_s == ST_WRITE)) ? addr_s : 32'h0;
      busy_r     <= (state_s == ST_READ) || (state_s == ST_WRITE);
      done_r     <= (state_s == ST_DONE);
      err_r      <= (state_s == ST_ERR);
    end
  end

  assign mem.mem_rd    = mem_rd_r;
  assign mem.mem_wr    = mem_wr_r;
  assign mem.mem_addr  = mem_addr_r;
  // Write data is the only combinational output; zero whenever not writing
  assign mem.mem_wdata = mem_wr_r ? merged_s : 32'h0;
  assign MDR_out       = mdr_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign err           = err_r;

endmodule
